// File: rtl/mfp_uart_tx_pkg.sv
// mfp_uart_tx_pkg: FSM state type and baud divisor helper shared by the UART transmitter files
package mfp_uart_tx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// mfp_uart_tx_fifo: single-clock fall-through byte FIFO; push/din in, pop in, dout head, full/empty/count registered out
module mfp_uart_tx_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nx;

    assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count_nx;
            full   <= count_nx == (AW+1)'(DEPTH);
            empty  <= count_nx == '0;
        end
    end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= din;

endmodule

// File: rtl/mfp_uart_tx.sv
// mfp_uart_tx: 8N1 UART transmitter with FIFO; HCLK/HRESETn, wr_en/wr_data/clr_ovf in, tx_full/tx_empty/tx_busy/tx_count/tx_ovf/UART_TX out
module mfp_uart_tx
    import mfp_uart_tx_pkg::*;
#(
    parameter int  CLK_FREQ_HZ = 50_000_000,
    parameter int  BAUD        = 115200,
    parameter int  FIFO_DEPTH  = 16,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clr_ovf,
    output logic        tx_full,
    output logic        tx_empty,
    output logic        tx_busy,
    output logic [AW:0] tx_count,
    output logic        tx_ovf,
    output logic        UART_TX
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD);
    localparam int CW       = $clog2(BAUD_DIV);

    tx_state_t     state, state_nx;
    logic [CW-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    sh, sh_nx, head;
    logic          pop, tick, line_nx;

    assign tick    = baud_cnt == CW'(BAUD_DIV - 1);
    assign tx_busy = state != IDLE;
    assign line_nx = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;

    mfp_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (wr_en && !tx_full),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        state_nx    = state;
        baud_cnt_nx = tick ? '0 : baud_cnt + CW'(1);
        bit_idx_nx  = bit_idx;
        sh_nx       = sh;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_nx = '0;
                if (!tx_empty) begin
                    pop        = 1'b1;
                    sh_nx      = head;
                    bit_idx_nx = '0;
                    state_nx   = START;
                end
            end
            START: state_nx = tick ? DATA : START;
            DATA: if (tick) begin
                sh_nx      = sh >> 1;
                bit_idx_nx = bit_idx + 3'd1;
                state_nx   = bit_idx == 3'd7 ? STOP : DATA;
            end
            STOP: state_nx = tick ? IDLE : STOP;
        endcase
    end

    // The line is registered from the state, so it trails tx_busy by one cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            UART_TX  <= 1'b1;
            tx_ovf   <= 1'b0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_idx  <= bit_idx_nx;
            sh       <= sh_nx;
            UART_TX  <= line_nx;
            tx_ovf   <= (wr_en && tx_full) ? 1'b1 : clr_ovf ? 1'b0 : tx_ovf;
        end
    end

endmodule
